// File: rtl/pca_pkg.sv
// pca_pkg: shared types and helpers for pipelined_carry_adder
// Holds the per-stage control record, chunk-width helper and parameter legality check.
// Each stage's data part (partial sum plus pending operand chunks) lives in
// pca_stage, because its width shrinks from stage to stage.
package pca_pkg;
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic bit width_ok(input int width, input int stages);
    return stages > 0 && width % stages == 0;
  endfunction
endpackage

// File: rtl/pca_stage.sv
// pca_stage: one chunk adder with its pipeline register and valid/ready handshake
// Ports: up_valid/load = upstream handshake (load doubles as upstream ready),
//        dn_ready/valid = downstream handshake, carry_in/carry = chunk carry chain,
//        z_in/z = data word (low 2*CW bits are this chunk's a,b; the rest are pending
//        operand chunks and finished sum chunks), ovf_in/ovf with PCA_OVF_EN.
// Optional macro PCA_OVF_EN adds the signed-overflow chain.
module pca_stage
  import pca_pkg::*;
#(
  parameter int CW = 4,
  parameter int IW = 16,
  parameter bit LAST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic up_valid,
  output logic load,
  input  logic dn_ready,
  output logic valid,
  input  logic carry_in,
  output logic carry,
  input  logic [IW-1:0] z_in,
  output logic [IW-CW-1:0] z
`ifdef PCA_OVF_EN
  ,
  input  logic ovf_in,
  output logic ovf
`endif
);
  stage_ctl_t ctl;
  logic [CW:0] add;
  logic [IW-CW-1:0] z_nx;
  assign add = {1'b0, z_in[CW-1:0]} + {1'b0, z_in[2*CW-1:CW]} + {{CW{1'b0}}, carry_in};
  // Loading whenever empty or the downstream takes our result gives full throughput.
  assign load = !ctl.valid || dn_ready;
  assign valid = ctl.valid;
  assign carry = ctl.carry;
  // The consumed a,b chunk drops off the bottom and its sum chunk enters at the top,
  // so after the last stage the word is exactly the finished sum.
  if (IW == 2*CW) begin : g_tail
    assign z_nx = add[CW-1:0];
  end else begin : g_body
    assign z_nx = {add[CW-1:0], z_in[IW-1:2*CW]};
  end
`ifdef PCA_OVF_EN
  logic ovf_nx;
  // Only the top chunk holds the operand MSBs; earlier stages just forward the chain.
  assign ovf_nx = LAST ? (z_in[CW-1] == z_in[2*CW-1]) && (add[CW-1] != z_in[CW-1]) : ovf_in;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      ctl <= '0;
      z <= '0;
`ifdef PCA_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (load) begin
      ctl.valid <= up_valid;
      if (up_valid) begin
        ctl.carry <= add[CW];
        z <= z_nx;
`ifdef PCA_OVF_EN
        ovf <= ovf_nx;
`endif
      end
    end
endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: {cout,sum} = a + b + cin over WIDTH bits in STAGES register stages
// Ports: clk, rst (sync, active high), in_valid/in_ready + a, b, cin operand side,
//        out_valid/out_ready + sum, cout result side, ovf (signed overflow) with PCA_OVF_EN.
// Optional macro PCA_OVF_EN adds the ovf output.
module pipelined_carry_adder
  import pca_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic cin,
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH-1:0] sum,
  output logic cout
`ifdef PCA_OVF_EN
  ,
  output logic ovf
`endif
);
  localparam int CW = chunk_w(WIDTH, STAGES);
  localparam bit WIDTH_OK = width_ok(WIDTH, STAGES);
  logic [STAGES:0] vld, rdy, car;
  logic [2*WIDTH-1:0] z0;
  if (!WIDTH_OK) begin : g_bad_width
    $error("pipelined_carry_adder: WIDTH must be divisible by STAGES");
  end
  assign vld[0] = in_valid;
  assign car[0] = cin;
  assign rdy[STAGES] = out_ready;
  assign in_ready = rdy[0];
  assign out_valid = vld[STAGES];
  assign cout = car[STAGES];
`ifdef PCA_OVF_EN
  logic [STAGES:0] ov;
  assign ov[0] = 1'b0;
  assign ovf = ov[STAGES];
`endif
  // Interleave operand chunks {b_n,a_n,...,b_0,a_0} so each stage eats the bottom 2*CW bits.
  for (genvar i = 0; i < STAGES; i++) begin : g_mix
    assign z0[2*i*CW +: CW] = a[i*CW +: CW];
    assign z0[(2*i+1)*CW +: CW] = b[i*CW +: CW];
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = 2*WIDTH - k*CW;
    logic [IW-1:0] zi;
    logic [IW-CW-1:0] zo;
    if (k == 0) begin : g_src
      assign zi = z0;
    end else begin : g_src
      assign zi = g_st[k-1].zo;
    end
    pca_stage #(.CW(CW), .IW(IW), .LAST(k == STAGES-1)) u_stage (
      .clk(clk),
      .rst(rst),
      .up_valid(vld[k]),
      .load(rdy[k]),
      .dn_ready(rdy[k+1]),
      .valid(vld[k+1]),
      .carry_in(car[k]),
      .carry(car[k+1]),
      .z_in(zi),
      .z(zo)
`ifdef PCA_OVF_EN
      ,
      .ovf_in(ov[k]),
      .ovf(ov[k+1])
`endif
    );
  end
  assign sum = g_st[STAGES-1].zo;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: scoreboard bench for pipelined_carry_adder (WIDTH=8, STAGES=2)
// Checks ovf as well when built with PCA_OVF_EN.
module tb_pipelined_carry_adder;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout;
  logic [W-1:0] a = '0, b = '0, sum;
`ifdef PCA_OVF_EN
  logic ovf;
`endif
  int total = 0, bad = 0, cyc = 0, last_stall = 0, w;
  bit rnd = 0, hold = 0;
  logic [W:0] held;
  typedef struct {
    logic [W-1:0] s;
    logic co;
    logic ov;
    int t;
  } exp_t;
  exp_t q[$];
  exp_t e;

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PCA_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [W-1:0] x, y, input logic c, input int t);
    exp_t r;
    int u, s;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    r.s = u[W-1:0];
    r.co = u >= (1 << W);
    r.ov = s > (1 << (W-1)) - 1 || s < -(1 << (W-1));
    r.t = t;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] x, y, input logic c, output int waits);
    waits = 0;
    a = x;
    b = y;
    cin = c;
    in_valid = 1;
    #2;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #2;
      waits++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Monitor: samples mid-cycle, pushes on accept, pops and compares on delivery.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      q.delete();
      hold = 0;
      last_stall = cyc;
    end else begin
      if (hold) chk("held_out", {cout, sum}, held);
      if (in_valid && in_ready) q.push_back(model(a, b, cin, cyc));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.co);
`ifdef PCA_OVF_EN
          chk("ovf", ovf, e.ov);
`endif
          if (last_stall < e.t) chk("latency", cyc - e.t, S);
        end
      end
      hold = out_valid && !out_ready;
      held = {cout, sum};
      if (!out_ready) last_stall = cyc;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef PCA_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 0;
    #1;
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    send(8'hFF, 8'h01, 0, w);
    drain();
    for (int i = 1; i <= 4; i++) begin
      send(8'(i * 16), 8'h01, 1, w);
      chk("b2b_wait", w, 0);
    end
    drain();
    out_ready = 0;
    send(8'h0A, 8'h14, 0, w);
    send(8'h1E, 8'h28, 1, w);
    #1;
    chk("stall_ready", in_ready, 0);
    chk("stall_occ", q.size(), 2);
    fork
      send(8'h50, 8'h60, 1, w);
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("stall_ready2", in_ready, 0);
        out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    send(8'h01, 8'h02, 0, w);
    send(8'h03, 8'h04, 0, w);
    rst = 1;
    @(negedge clk);
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    rst = 0;
    out_ready = 1;
    repeat (6) @(negedge clk);
    chk("postrst_valid", out_valid, 0);
    send(8'h7F, 8'h01, 0, w);
    send(8'h80, 8'h80, 0, w);
    send(8'h05, 8'h03, 0, w);
    drain();
    rnd = 1;
    repeat (300) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), w);
    end
    rnd = 0;
    @(negedge clk);
    out_ready = 1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
